// File: rtl/threshold_bitpack.sv
// threshold_bitpack: packs binary (0x00/0xFF) SIMD pixel beats into OUT_WIDTH-bit
// words, one bit per pixel, flags the last word of each frame, counts foreground
// pixels per frame and latches a sticky error on non-binary pixel values.
module threshold_bitpack #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int SIMD_WIDTH = 4,
    parameter int OUT_WIDTH  = 32,
    localparam int CW        = $clog2(WIDTH*HEIGHT+1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [SIMD_WIDTH*8-1:0] in_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [OUT_WIDTH-1:0]    out_data_o,
    output logic                    out_last_o,
    output logic [CW-1:0]           fg_count_o,
    output logic                    frame_done_o,
    output logic                    err_o
);

    localparam int BPW = OUT_WIDTH / SIMD_WIDTH;
    localparam int WPF = WIDTH * HEIGHT / OUT_WIDTH;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WCW = (WPF > 1) ? $clog2(WPF) : 1;

    logic [BCW-1:0]        beat_cnt;
    logic [WCW-1:0]        word_cnt;
    logic [CW-1:0]         run_cnt;
    logic [OUT_WIDTH-1:0]  acc;
    logic [OUT_WIDTH-1:0]  word_next;
    logic [SIMD_WIDTH-1:0] lane_bits;
    logic                  lane_err;
    logic [CW-1:0]         beat_pop;
    logic                  beat_last;
    logic                  word_last;
    logic                  accept;
    logic                  load;
    logic                  frame_end;

    assign beat_last = (beat_cnt == BCW'(BPW-1));
    assign word_last = (word_cnt == WCW'(WPF-1));

    // Only the final beat of a word can stall, and only while the held word is unconsumed.
    assign in_ready_o = rst_ni && !(beat_last && out_valid_o && !out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign load       = accept && beat_last;
    assign frame_end  = load && word_last;

    // Per-lane binarisation, non-binary detection and popcount of the current beat.
    always_comb begin
        lane_bits = '0;
        lane_err  = 1'b0;
        beat_pop  = '0;
        for (int k = 0; k < SIMD_WIDTH; k++) begin
            lane_bits[k] = |in_data_i[8*k +: 8];
            lane_err     = lane_err ||
                           ((in_data_i[8*k +: 8] != 8'h00) && (in_data_i[8*k +: 8] != 8'hFF));
            beat_pop     = beat_pop + CW'(|in_data_i[8*k +: 8]);
        end
    end

    // Accumulator with the current beat merged in, so the final beat loads straight out.
    always_comb begin
        word_next = acc;
        word_next[beat_cnt*SIMD_WIDTH +: SIMD_WIDTH] = lane_bits;
    end

    // Beat/word position tracking and partial-word accumulation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_cnt <= '0;
            word_cnt <= '0;
            acc      <= '0;
        end else if (accept) begin
            acc <= word_next;
            if (beat_last) begin
                beat_cnt <= '0;
                word_cnt <= word_last ? '0 : word_cnt + WCW'(1);
            end else begin
                beat_cnt <= beat_cnt + BCW'(1);
            end
        end
    end

    // Single-entry output register; a load in the drain cycle replaces the old word.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
        end else if (load) begin
            out_valid_o <= 1'b1;
            out_data_o  <= word_next;
            out_last_o  <= word_last;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
        end
    end

    // Foreground count per frame, published on the frame's final accepted beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            run_cnt      <= '0;
            fg_count_o   <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= frame_end;
            if (accept) begin
                if (frame_end) begin
                    fg_count_o <= run_cnt + beat_pop;
                    run_cnt    <= '0;
                end else begin
                    run_cnt <= run_cnt + beat_pop;
                end
            end
        end
    end

    // Sticky non-binary pixel error, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (accept && lane_err) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_threshold_bitpack.sv
// Directed bench for threshold_bitpack: frame streams with hand-computed words and
// counts, a reference queue of expected words checked at every output handshake.
module tb_threshold_bitpack;

    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic [CW-1:0] fg_count;
    logic          frame_done;
    logic          err;

    always #5 clk = ~clk;

    threshold_bitpack dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .fg_count_o   (fg_count),
        .frame_done_o (frame_done),
        .err_o        (err)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_data[$];
    logic        exp_last[$];
    int          exp_fg[$];

    int          m_beat;
    int          m_word;
    int          m_run;
    logic [31:0] m_acc;

    int          seen_words;
    int          seen_last;
    int          seen_done;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_beat = 0;
        m_word = 0;
        m_run  = 0;
        m_acc  = '0;
        exp_data.delete();
        exp_last.delete();
        exp_fg.delete();
    endtask

    task automatic clear_counts();
        seen_words = 0;
        seen_last  = 0;
        seen_done  = 0;
    endtask

    // Reference behaviour of one accepted beat.
    task automatic model_beat(input logic [31:0] d);
        for (int k = 0; k < 4; k++) begin
            m_acc[m_beat*4 + k] = (d[8*k +: 8] != 8'h00);
            m_run += (d[8*k +: 8] != 8'h00) ? 1 : 0;
        end
        if (m_beat == 7) begin
            exp_data.push_back(m_acc);
            exp_last.push_back(m_word == 127);
            if (m_word == 127) begin
                exp_fg.push_back(m_run);
                m_run  = 0;
                m_word = 0;
            end else begin
                m_word++;
            end
            m_beat = 0;
        end else begin
            m_beat++;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [31:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("beat_accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        model_beat(d);
        in_valid = 1'b0;
    endtask

    task automatic finish_frames(input string tag, input int fg, input int frames);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_fg_count"}, fg_count, fg);
        check({tag, "_done_pulses"}, seen_done, frames);
        check({tag, "_last_words"}, seen_last, frames);
        check({tag, "_word_total"}, seen_words, 128*frames);
        check({tag, "_words_pending"}, exp_data.size(), 0);
        clear_counts();
    endtask

    // Output monitor: ordered word/last comparison, frame count, stall stability.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (prev_stall && out_valid) begin
                check("stall_hold_data", out_data, prev_data);
                check("stall_hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                seen_words++;
                if (out_last) seen_last++;
                check("word_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) begin
                    check("word_data", out_data, exp_data.pop_front());
                    check("word_last", out_last, exp_last.pop_front());
                end
            end
            if (frame_done) begin
                seen_done++;
                check("done_expected", exp_fg.size() != 0, 1);
                if (exp_fg.size() != 0) check("done_fg_count", fg_count, exp_fg.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        clear_counts();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_fg_count", fg_count, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        @(negedge clk);

        // All-ones frame
        for (int w = 0; w < 128; w++)
            for (int b = 0; b < 8; b++)
                send_beat(32'hFFFF_FFFF);
        finish_frames("ones", 4096, 1);
        check("ones_err", err, 0);

        // Lane order: only lane 0 set
        for (int b = 0; b < 8; b++) send_beat(32'h0000_00FF);
        #1;
        check("lane_first_word", out_data, 32'h1111_1111);
        @(negedge clk);
        for (int i = 8; i < 1024; i++) send_beat(32'h0000_00FF);
        finish_frames("lane", 1024, 1);

        // Back-to-back frames: all ones, then first half ones
        for (int i = 0; i < 1024; i++) send_beat(32'hFFFF_FFFF);
        send_beat(32'hFFFF_FFFF);
        #1;
        check("b2b_fg_a", fg_count, 4096);
        @(negedge clk);
        for (int i = 1; i < 1024; i++) send_beat((i < 512) ? 32'hFFFF_FFFF : 32'h0);
        finish_frames("b2b", 2048, 2);

        // Backpressure: words alternate 0x5A5A5A5A / 0xA5A5A5A5
        out_ready = 1'b0;
        for (int b = 0; b < 8; b++)
            send_beat(((b % 2) == 0) ? 32'hFF00_FF00 : 32'h00FF_00FF);
        for (int b = 0; b < 7; b++)
            send_beat(((b % 2) == 1) ? 32'hFF00_FF00 : 32'h00FF_00FF);
        #1;
        check("bp_ready_low", in_ready, 0);
        check("bp_held_valid", out_valid, 1);
        check("bp_held_word", out_data, 32'h5A5A_5A5A);
        repeat (5) @(negedge clk);
        #1;
        check("bp_ready_still_low", in_ready, 0);
        check("bp_word_still_held", out_data, 32'h5A5A_5A5A);
        repeat (7) @(negedge clk);
        out_ready = 1'b1;
        send_beat(32'hFF00_FF00);
        for (int w = 2; w < 128; w++)
            for (int b = 0; b < 8; b++)
                send_beat((((w + b) % 2) == 0) ? 32'hFF00_FF00 : 32'h00FF_00FF);
        finish_frames("bp", 2048, 1);

        // Non-binary pixel in lane 2 of the first beat
        #1;
        check("err_before", err, 0);
        @(negedge clk);
        send_beat(32'h0080_0000);
        #1;
        check("err_rise", err, 1);
        @(negedge clk);
        for (int b = 1; b < 8; b++) send_beat(32'h0);
        #1;
        check("err_word", out_data, 32'h0000_0004);
        @(negedge clk);
        for (int i = 8; i < 1024; i++) send_beat(32'h0);
        finish_frames("err", 1, 1);
        for (int i = 0; i < 1024; i++) send_beat(32'h0);
        finish_frames("err_next", 0, 1);
        check("err_sticky", err, 1);

        // Reset mid-frame
        @(negedge clk);
        for (int b = 0; b < 5; b++) send_beat(32'hFFFF_FFFF);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_fg_count", fg_count, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_err", err, 0);
        rst_n = 1'b1;
        model_reset();
        clear_counts();
        @(negedge clk);
        for (int i = 0; i < 1024; i++) send_beat(32'h0);
        finish_frames("post_rst", 0, 1);
        check("post_rst_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/threshold_bitpack.md
# threshold_bitpack

Downstream stage of the SIMD threshold unit. It accepts beats of `SIMD_WIDTH` thresholded 8-bit pixels, each 0 or 255, and packs them one bit per pixel into `OUT_WIDTH`-bit words for the frame buffer or DMA. It tracks frame position to flag the final word of each frame. It reports a per-frame foreground pixel count and a sticky error for non-binary input values.

## Interface
- `WIDTH`, 64: image width in pixels; multiple of `OUT_WIDTH`.
- `HEIGHT`, 64: image height in rows.
- `SIMD_WIDTH`, 4: pixels per input beat; divides `OUT_WIDTH`.
- `OUT_WIDTH`, 32: packed output word width.
- Derived:
  - BPW = `OUT_WIDTH`/`SIMD_WIDTH` (8): beats per word.
  - WPF = `WIDTH`*`HEIGHT`/`OUT_WIDTH` (128): words per frame.
  - CW = $clog2(`WIDTH`*`HEIGHT`+1): count width.

Ports:
- `clk_i` in 1: single clock; all state changes on its rising edge.
- `rst_ni` in 1: synchronous, active-low reset.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: input beat accepted when `in_valid_i` and `in_ready_o` are both high.
- `in_data_i` in `SIMD_WIDTH`*8: lane k is bits [8k+7:8k]; it is pixel column col+k.
- `out_valid_o` out 1: packed word valid.
- `out_ready_i` in 1: downstream accepts the word.
- `out_data_o` out `OUT_WIDTH`: packed bits; bit 0 is the leftmost pixel.
- `out_last_o` out 1: qualifies `out_data_o` as the final word of the frame.
- `fg_count_o` out CW: number of pixels set to 1 in the last completed frame.
- `frame_done_o` out 1: one-cycle pulse when `fg_count_o` updates.
- `err_o` out 1: sticky flag; set when any accepted lane is not 0x00 or 0xFF.

## Operation
- **Pixel to bit:** each accepted lane maps to bit = (pixel != 0). So 0x80 packs as 1 and sets `err_o`.
- **Accumulator:**
  - `beat_cnt` counts 0..BPW-1.
  - Beat b writes lanes to accumulator bits [b*`SIMD_WIDTH` +: `SIMD_WIDTH`], lane k to bit b*`SIMD_WIDTH`+k.
  - When the beat with `beat_cnt`=BPW-1 is accepted, the assembled word (including that beat) loads the output register and sets `out_valid_o`.
  - `beat_cnt` wraps to 0.
- **Word counter:**
  - `word_cnt` counts 0..WPF-1 and increments on each word load.
  - `out_last_o` is set with the word loaded when `word_cnt`=WPF-1; `word_cnt` then wraps to 0.
- **Output register:** single entry.
  - Cleared when `out_valid_o` and `out_ready_i` are both high, unless a new word loads in the same cycle.
  - Simultaneous drain and load: the new word replaces the old one and `out_valid_o` stays 1.
- **Ready:**
  - `in_ready_o` = !(`beat_cnt`==BPW-1 && `out_valid_o` && !`out_ready_i`).
  - It is combinational from `out_ready_i` and registered state only; it never depends on `in_valid_i`.
  - Beats 0..BPW-2 are always accepted, even while the output is stalled.
- **Foreground count:**
  - `run_cnt` adds the popcount of accepted lanes each beat.
  - On acceptance of the frame's final beat: `fg_count_o` <= `run_cnt` + popcount(that beat), `run_cnt` <= 0, and `frame_done_o` pulses the following cycle.
  - `fg_count_o` holds until the next frame completes.
- **Error:** `err_o` is set the cycle after an offending beat is accepted and cleared only by reset.
- **Frames:** back-to-back frames need no idle cycles between them.

## Timing
- **Reset** (`rst_ni` low at a clock edge):
  - `beat_cnt`, `word_cnt` and `run_cnt` clear to 0.
  - All outputs clear to 0: `out_valid_o`, `out_data_o`, `out_last_o`, `fg_count_o`, `frame_done_o`, `err_o`.
  - `in_ready_o` is forced to 0 while `rst_ni` is low and returns to 1 the first cycle after release.
  - Reset mid-frame discards the partial word and partial count; the next accepted beat is beat 0 of word 0 of a new frame.
- **Latency:** the word is valid in the cycle after its final beat is accepted.
- **Throughput:** with `out_ready_i` held at 1, the block sustains one beat per cycle.
- **Output stability:** while `out_valid_o`=1 and `out_ready_i`=0, `out_data_o` and `out_last_o` hold stable.
- **`frame_done_o`:** asserts exactly one cycle after the final beat of the frame is accepted, independent of output backpressure.

## Test plan
- **All-ones frame:** stream 1024 beats of all 0xFF with `out_ready_i`=1.
  - Expect 128 words of 0xFFFFFFFF, `out_last_o` only on the 128th.
  - `fg_count_o`=4096; `frame_done_o` pulses once; `err_o`=0.
- **Lane order:** every beat {lane0=0xFF, lanes1-3=0x00} → every word 0x11111111 and `fg_count_o`=1024.
- **Backpressure:** hold `out_ready_i`=0 for 20 cycles after the first word.
  - Beats 0-6 of word 2 are accepted; `in_ready_o` drops at beat 7.
  - After release, words emerge in order and unaltered; none are lost or duplicated.
- **Error:** one lane = 0x80 with other lanes 0.
  - Packed bit = 1 and `err_o` rises the next cycle.
  - `err_o` stays 1 through the rest of the frame and the next frame.
- **Reset mid-frame:** after 5 beats of 0xFF, pulse `rst_ni` low for 1 cycle.
  - All outputs read 0.
  - The next frame of 0x00 gives words 0x00000000 and `fg_count_o`=0.
- **Back-to-back frames:** frame A all 0xFF, then frame B half 0xFF with no gap.
  - `fg_count_o` reads 4096 then 2048.
  - `out_last_o` asserts once per frame; `word_cnt` wraps correctly.
